// File: rtl/aidan_mcnay_deserializer_pkg.sv
// Shared definitions for the deserializer and the prime detector's controller:
// control state encoding and the bit-counter width helper.
package aidan_mcnay_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // A counter that reaches n-1 needs this many bits.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aidan_mcnay_sipo.sv
// Serial-in/parallel-out shift register. The newest bit enters at the LSB,
// so after nbits shifts the first bit received sits at the MSB.
module aidan_mcnay_sipo #(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             data_in,
  output logic [nbits-1:0] data_out
);

  logic [nbits-1:0] data_q;

  // Shift register: moves only on an enabled cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= {data_q[nbits-2:0], data_in};
    end else begin
      data_q <= data_q;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/aidan_mcnay_deserializer.sv
// Framing stage: gathers nbits serial bits (MSB first) into a word and holds
// it on a valid/ready output until the detector core takes it.
module aidan_mcnay_deserializer
  import aidan_mcnay_deserializer_pkg::*;
#(
  parameter int nbits = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nbits-1:0] out_data,
  output logic             busy
);

  localparam int CW = cnt_width(nbits);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          accept_s;

  // A bit is consumed only when offered, accepted, and not being aborted.
  assign in_ready  = (state_q != HOLD);
  assign accept_s  = in_valid & in_ready & ~clear;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == SHIFT);

  // State and bit-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; clear overrides everything and drops the frame.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_d = SHIFT;
            count_d = CW'(1);
          end else begin
            count_d = '0;
          end
        end
        SHIFT: begin
          if (accept_s) begin
            if (count_q == CW'(nbits - 1)) begin
              state_d = HOLD;
              count_d = '0;
            end else begin
              count_d = count_q + CW'(1);
            end
          end else begin
            count_d = count_q;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  aidan_mcnay_sipo #(.nbits(nbits)) u_sipo (
    .clk      (clk),
    .reset    (reset),
    .en       (accept_s),
    .data_in  (in_data),
    .data_out (out_data)
  );

endmodule
